// File: rtl/riscy_fetch.sv
// RISCY fetch stage: 7-bit PC, 11-bit IR and memory-address mux feeding SC; updates land one edge after the strobe, MEM_ADDR mux is zero-latency.
// Optional return-address stack for CALL/RET is built when RISCY_FETCH_CALLSTACK_EN is defined.
module riscy_fetch #(
    parameter logic [6:0] RST_VEC   = 7'h00,
    parameter int         STK_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [10:0] INSTR_IN,
    input  logic        IR_EN,
    input  logic        PC_EN,
    input  logic        PC_LOAD,
    input  logic        RAM_CS,
    output logic [3:0]  OPCODE,
    output logic [6:0]  ADDR,
    output logic [6:0]  MEM_ADDR,
    output logic [6:0]  PC_OUT,
    output logic        STK_ERR
);

    if (STK_DEPTH < 2 || STK_DEPTH > 8) begin : g_bad_depth
        $error("riscy_fetch: STK_DEPTH must be in 2..8");
    end

    logic [6:0]  pc;
    logic [10:0] ir;

    assign OPCODE   = ir[10:7];
    assign ADDR     = ir[6:0];
    assign PC_OUT   = pc;
    assign MEM_ADDR = RAM_CS ? ir[6:0] : pc;

`ifdef RISCY_FETCH_CALLSTACK_EN
    localparam int SPW = $clog2(STK_DEPTH + 1);
    localparam int IW  = $clog2(STK_DEPTH);
    localparam logic [SPW-1:0] FULL = SPW'(STK_DEPTH);

    logic [6:0]     stk [STK_DEPTH];
    logic [SPW-1:0] sp;
    logic           err;
    logic [IW-1:0]  wr_idx;
    logic [IW-1:0]  rd_idx;
    logic           is_call;
    logic           is_ret;

    assign wr_idx  = IW'(sp);
    assign rd_idx  = IW'(sp - SPW'(1));
    assign is_call = (ir[10:7] == 4'hE);
    assign is_ret  = (ir[10:7] == 4'hF);
    assign STK_ERR = err;

    // Loads always decode the IR held before this edge, even if IR_EN replaces it now.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc  <= RST_VEC;
            ir  <= 11'h000;
            sp  <= '0;
            err <= 1'b0;
            for (int i = 0; i < STK_DEPTH; i++) stk[i] <= 7'h00;
        end else begin
            if (IR_EN) ir <= INSTR_IN;
            if (PC_LOAD) begin
                if (is_call) begin
                    pc <= ir[6:0];
                    if (sp == FULL) begin
                        err <= 1'b1;
                    end else begin
                        stk[wr_idx] <= pc + 7'd1;
                        sp          <= sp + SPW'(1);
                    end
                end else if (is_ret) begin
                    if (sp == '0) begin
                        pc  <= RST_VEC;
                        err <= 1'b1;
                    end else begin
                        pc <= stk[rd_idx];
                        sp <= sp - SPW'(1);
                    end
                end else begin
                    pc <= ir[6:0];
                end
            end else if (PC_EN) begin
                pc <= pc + 7'd1;
            end
        end
    end
`else
    assign STK_ERR = 1'b0;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc <= RST_VEC;
            ir <= 11'h000;
        end else begin
            if (IR_EN) ir <= INSTR_IN;
            if (PC_LOAD)     pc <= ir[6:0];
            else if (PC_EN)  pc <= pc + 7'd1;
        end
    end
`endif

endmodule

// File: doc/riscy_fetch.md
# riscy_fetch

Program-counter and instruction-register stage of the RISCY CPU, sitting directly upstream of the sequence controller `SC`. It holds the 7-bit program counter and the 11-bit instruction register, and presents `OPCODE`/`ADDR` to `SC`. It consumes `SC`'s `PC_EN`, `PC_LOAD`, `IR_EN` and `RAM_CS` strobes and drives the memory address bus. An optional return-address stack adds CALL/RET support.

## Interface
- `RST_VEC`, default 7'h00: PC value after reset.
- `STK_DEPTH`, default 4: return-stack entries (2..8); only used with the macro.
- `CLK` in 1: single clock, all state updates on rising edge.
- `RST` in 1: reset, asynchronous, active-high.
- `INSTR_IN` in 11: instruction word from program memory at `MEM_ADDR`; [10:7] opcode, [6:0] operand address.
- `IR_EN` in 1: capture `INSTR_IN` into the IR (from `SC`).
- `PC_EN` in 1: increment PC (from `SC`).
- `PC_LOAD` in 1: load PC with branch/jump target (from `SC`).
- `RAM_CS` in 1: data-memory cycle; selects operand address onto `MEM_ADDR` (from `SC`).
- `OPCODE` out 4: IR[10:7], to `SC`.
- `ADDR` out 7: IR[6:0], to `SC`.
- `MEM_ADDR` out 7: combinational; IR[6:0] when `RAM_CS`=1, else PC.
- `PC_OUT` out 7: current PC (debug/trace).
- `STK_ERR` out 1: sticky stack overflow/underflow flag.

## Operation
- PC register, 7 bits, modulo-128: increment 7'h7F -> 7'h00, no flag.
- PC priority per edge: `PC_LOAD` > `PC_EN` > hold.
- Load target: IR[6:0] for all opcodes except RET (macro build only), which uses the stack top.
- IR is 11 bits, loads `INSTR_IN` when `IR_EN`=1, else holds. `OPCODE`/`ADDR` are registered IR fields, never combinational from `INSTR_IN`.
- `IR_EN` with `PC_EN` in the same cycle: IR captures the word at the pre-increment PC; PC advances. This is the normal fetch cycle.
- `IR_EN` with `PC_LOAD` in the same cycle: IR captures the new word; PC loads using the *old* IR operand/opcode.
- Opcodes handled by `SC`: 0000 LOAD, 0001 STORE, 0010 ADD, 1000 JUMP, 1100 BRANCH-IF-C. This block does not evaluate conditions; `SC` asserts `PC_LOAD` only when a branch is taken.
- Without the macro, `STK_ERR` is tied to 0.

## Timing
- Reset values: PC=`RST_VEC`, IR=11'h000, so `OPCODE`=4'h0, `ADDR`=7'h00, `PC_OUT`=`RST_VEC`, `MEM_ADDR`=`RST_VEC` (if `RAM_CS`=0). `STK_ERR`=0; stack pointer=0, entries 0.
- Reset asserted mid-operation clears all of the above immediately and asynchronously. Strobes in the release cycle are honoured from the first rising edge after `RST` falls.
- Latencies:
  - `PC_OUT`/`MEM_ADDR` reflect a load or increment one edge after the strobe.
  - `OPCODE`/`ADDR` valid one edge after `IR_EN`.
  - `MEM_ADDR` mux switches same-cycle with `RAM_CS` (zero latency).
- No handshake: the strobes are single-cycle qualifiers. Holding a strobe high N cycles has N effects (e.g. `PC_EN` high 3 cycles = +3).

## Configuration
- Macro: `RISCY_FETCH_CALLSTACK_EN`.
- Defined: a `STK_DEPTH`-entry LIFO of return addresses is built.
  - Opcode 1110 CALL: on `PC_LOAD`, push PC+1 (mod 128) and load IR[6:0].
  - Opcode 1111 RET: on `PC_LOAD`, pop into PC.
  - Push when full: no write, PC still loads the target, `STK_ERR` set.
  - Pop when empty: PC loads `RST_VEC`, `STK_ERR` set.
  - `STK_ERR` clears only on reset.
- Undefined: no stack logic; 1110/1111 load IR[6:0] like JUMP; `STK_ERR`=0.

## Test plan
- Reset with `RST_VEC`=7'h05, then `PC_EN`+`IR_EN` on one edge with `INSTR_IN`=11'h10A -> IR=11'h10A (`OPCODE`=4'h2, `ADDR`=7'h0A), PC=7'h06.
- PC=7'h7F, `PC_EN` pulse -> PC=7'h00, no other state change.
- IR=JUMP 7'h78 (11'h478), `PC_LOAD` and `PC_EN` together -> PC=7'h78 (load wins).
- `RAM_CS`=1 with IR `ADDR`=7'h28, PC=7'h10 -> `MEM_ADDR`=7'h28 same cycle; `RAM_CS`=0 -> 7'h10.
- Assert `RST` asynchronously between edges while PC=7'h33 -> PC, `OPCODE`, `ADDR`, `STK_ERR` reset without a clock edge.
- Macro build, `STK_DEPTH`=4: five CALLs then five RETs -> returns pop in LIFO order; the 5th CALL and 5th RET set `STK_ERR`; the 5th RET loads `RST_VEC`.
